// File: rtl/ro_fault_ctrl.sv
// ro_fault_ctrl: arms on request and fires a masked set of ring-oscillator enables
// for a configured width, a configured delay after a trigger rising edge.
module ro_fault_ctrl #(
    parameter int NUM_RO = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_width,
    input  logic [NUM_RO-1:0] cfg_mask,
    input  logic              arm,
    input  logic              abort,
    input  logic              trigger,
    output logic [NUM_RO-1:0] ro_enable,
    output logic              busy,
    output logic              done,
    output logic [7:0]        shot_count
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARMED = 3'd1;
    localparam logic [2:0] DELAY = 3'd2;
    localparam logic [2:0] FIRE  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, delay_r, width_r, width_eff;
    logic [NUM_RO-1:0] mask_r;
    logic              trig_q, trig_edge;

    assign trig_edge = trigger & ~trig_q;
    assign width_eff = (width_r == '0) ? CNT_W'(1) : width_r;
    assign busy      = state != IDLE;

    // outputs lag the state by one edge, so a zero delay still fires one edge after the trigger
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:  state_n = arm ? ARMED : IDLE;
                ARMED: if (trig_edge) begin
                    state_n = (delay_r == '0) ? FIRE : DELAY;
                    cnt_n   = (delay_r == '0) ? width_eff : delay_r;
                end
                DELAY: begin
                    state_n = (cnt == CNT_W'(1)) ? FIRE : DELAY;
                    cnt_n   = (cnt == CNT_W'(1)) ? width_eff : cnt - CNT_W'(1);
                end
                FIRE: begin
                    state_n = (cnt == CNT_W'(1)) ? DONE : FIRE;
                    cnt_n   = cnt - CNT_W'(1);
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            delay_r    <= '0;
            width_r    <= '0;
            mask_r     <= '0;
            trig_q     <= 1'b0;
            ro_enable  <= '0;
            done       <= 1'b0;
            shot_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            trig_q    <= trigger;
            ro_enable <= (state == FIRE && !abort) ? mask_r : '0;
            done      <= (state == DONE) && !abort;
            if (state == IDLE && cfg_we) begin
                delay_r <= cfg_delay;
                width_r <= cfg_width;
                mask_r  <= cfg_mask;
            end
            if (state == FIRE && state_n == DONE && shot_count != 8'd255)
                shot_count <= shot_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_ro_fault_ctrl.sv
// tb_ro_fault_ctrl: scoreboard bench; expected per-cycle outputs are queued when a
// trigger is driven and popped as the DUT produces them.
module tb_ro_fault_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [15:0] cfg_delay = '0;
    logic [15:0] cfg_width = '0;
    logic [7:0]  cfg_mask = '0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        trigger = 1'b0;
    logic [7:0]  ro_enable;
    logic        busy;
    logic        done;
    logic [7:0]  shot_count;

    typedef struct {
        logic [7:0] en;
        logic       dn;
        logic       bs;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    int   total_shots = 0;

    ro_fault_ctrl #(.NUM_RO(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_delay(cfg_delay),
        .cfg_width(cfg_width), .cfg_mask(cfg_mask), .arm(arm), .abort(abort),
        .trigger(trigger), .ro_enable(ro_enable), .busy(busy), .done(done),
        .shot_count(shot_count)
    );

    always #5 clk = ~clk;

    task automatic arm_with(input int d, input int w, input logic [7:0] m);
        @(negedge clk);
        cfg_we = 1'b1; cfg_delay = 16'(d); cfg_width = 16'(w); cfg_mask = m; arm = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; arm = 1'b0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_busy: got %b want 1", busy);
        end
    endtask

    task automatic fire_and_check(input int d, input int w, input logic [7:0] m, input string name);
        int   wp;
        exp_t e;
        wp = (w == 0) ? 1 : w;
        @(negedge clk);
        trigger = 1'b1;
        for (int j = 0; j <= d + wp + 1; j++)
            q.push_back('{en: (j >= d + 1 && j <= d + wp) ? m : 8'h00,
                          dn: (j == d + wp + 1), bs: (j <= d + wp)});
        for (int j = 0; j <= d + wp + 1; j++) begin
            @(negedge clk);
            if (j == 0) trigger = 1'b0;
            e = q.pop_front();
            n_chk++;
            if (ro_enable !== e.en || done !== e.dn || busy !== e.bs) begin
                n_fail++;
                $display("FAIL %s cyc%0d: en=%h done=%b busy=%b want en=%h done=%b busy=%b",
                         name, j, ro_enable, done, busy, e.en, e.dn, e.bs);
            end
        end
        if (exp_cnt < 255) exp_cnt++;
        total_shots++;
        n_chk++;
        if (shot_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s shot_count: got %0d want %0d", name, shot_count, exp_cnt);
        end
    endtask

    task automatic test_reset;
        #12;
        n_chk++;
        if (ro_enable !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || shot_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: en=%h busy=%b done=%b cnt=%0d want 0s", ro_enable, busy, done, shot_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        arm_with(3, 4, 8'hA5);
        fire_and_check(3, 4, 8'hA5, "basic_d3w4");
        arm_with(0, 0, 8'hFF);
        fire_and_check(0, 0, 8'hFF, "zero_d0w0");
        arm_with(5, 2, 8'h3C);
        fire_and_check(5, 2, 8'h3C, "d5w2");
    endtask

    task automatic test_ignore_idle_trigger;
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b0 || ro_enable !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_trigger: busy=%b en=%h want 0/00", busy, ro_enable);
            end
        end
    endtask

    task automatic test_held_trigger;
        @(negedge clk); trigger = 1'b1;
        arm_with(2, 2, 8'h3C);
        repeat (4) begin
            @(negedge clk);
            n_chk++;
            if (ro_enable !== 8'h00 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL held_trigger: en=%h busy=%b want 00/1", ro_enable, busy);
            end
        end
        cfg_we = 1'b1; cfg_mask = 8'h01; cfg_delay = 16'd0; cfg_width = 16'd1;
        @(negedge clk);
        cfg_we = 1'b0; trigger = 1'b0;
        fire_and_check(2, 2, 8'h3C, "cfg_locked");
    endtask

    task automatic test_abort;
        arm_with(1, 10, 8'hF0);
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (ro_enable !== 8'hF0) begin
            n_fail++;
            $display("FAIL abort_prefire: en=%h want f0", ro_enable);
        end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_chk++;
        if (ro_enable !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: en=%h busy=%b done=%b want 00/0/0", ro_enable, busy, done);
        end
        repeat (12) begin
            @(negedge clk);
            n_chk++;
            if (done !== 1'b0 || ro_enable !== 8'h00) begin
                n_fail++;
                $display("FAIL abort_after: done=%b en=%h want 0/00", done, ro_enable);
            end
        end
        n_chk++;
        if (shot_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL abort_count: got %0d want %0d", shot_count, exp_cnt);
        end
    endtask

    task automatic test_saturation;
        while (total_shots < 256) begin
            arm_with(0, 1, 8'h81);
            fire_and_check(0, 1, 8'h81, "sat");
            if (total_shots == 255 || total_shots == 256) begin
                n_chk++;
                if (shot_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL saturate shot%0d: got %0d want 255", total_shots, shot_count);
                end
            end
        end
    endtask

    task automatic test_reset_mid_fire;
        arm_with(0, 6, 8'hFF);
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ro_enable !== 8'hFF) begin
            n_fail++;
            $display("FAIL rst_prefire: en=%h want ff", ro_enable);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (ro_enable !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || shot_count !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_async: en=%h busy=%b done=%b cnt=%0d want 0s", ro_enable, busy, done, shot_count);
        end
        @(negedge clk); rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
        fire_and_check(0, 0, 8'h00, "post_rst_cfg");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_ignore_idle_trigger;
        test_held_trigger;
        test_abort;
        test_saturation;
        test_reset_mid_fire;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
